// File: rtl/array_20_pkg.sv
// Shared definitions for the array_20 controller: geometry, FSM states, grant types
// and the request bundle presented to the single-port array macro.
package array_20_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 516;
  localparam int MASK_W = 2;
  localparam int SEG_W  = DATA_W / MASK_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INIT = 2'd1,
    GNT_RD   = 2'd2,
    GNT_WR   = 2'd3
  } grant_e;

  typedef struct packed {
    logic              en;
    logic              wmode;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/array_20_rsp_fifo.sv
// Small synchronous response FIFO holding read data until the consumer takes it.
// The head entry is presented directly, so data stays stable while not popped.
module array_20_rsp_fifo
  import array_20_pkg::*;
#(
  parameter int RSP_DEPTH = 2,
  parameter int WIDTH     = DATA_W,
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [RSP_DEPTH];
  logic             do_push;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(RSP_DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/array_20_arb.sv
// Controller for the 32x516 single-port array: zero-initialises after reset/flush,
// then round-robins the port between read and write requesters; reads return via a FIFO.
module array_20_arb
  import array_20_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  output logic              init_done,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_ptr;      // 0: read wins the next contention, 1: write wins
  logic              inflight;
  grant_e            grant;
  sram_req_t         req;
  logic              contended;
  logic              rd_ok;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;

  // A read may be granted only if its data is guaranteed a FIFO slot on arrival.
  assign pop       = rsp_valid & rsp_ready;
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign rd_ok     = (occupancy < (CNT_W + 1)'(RSP_DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rr_ptr    <= 1'b0;
      inflight  <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == RUN);
      inflight  <= (grant == GNT_RD);
      if (contended) rr_ptr <= ~rr_ptr;
      if (flush)               init_cnt <= '0;
      else if (state == INIT)  init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (!flush && init_cnt == ADDR_W'(DEPTH - 1)) state_next = RUN;
      RUN:     if (flush) state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = GNT_NONE;
    contended = 1'b0;
    req       = '0;
    rd_ready  = 1'b0;
    wr_ready  = 1'b0;

    case (state)
      INIT: grant = GNT_INIT;
      RUN: begin
        if (!flush) begin
          contended = rd_valid & rd_ok & wr_valid;
          if (contended)             grant = rr_ptr ? GNT_WR : GNT_RD;
          else if (rd_valid & rd_ok) grant = GNT_RD;
          else if (wr_valid)         grant = GNT_WR;
        end
      end
      default: grant = GNT_NONE;
    endcase

    case (grant)
      GNT_INIT: begin
        req.en    = 1'b1;
        req.wmode = 1'b1;
        req.addr  = init_cnt;
        req.wmask = '1;
      end
      GNT_RD: begin
        rd_ready = 1'b1;
        req.en   = 1'b1;
        req.addr = rd_addr;
      end
      GNT_WR: begin
        // A fully masked write is acknowledged but never touches the array.
        wr_ready  = 1'b1;
        req.en    = |wr_mask;
        req.wmode = 1'b1;
        req.addr  = wr_addr;
        req.wmask = wr_mask;
        req.wdata = wr_data;
      end
      default: ;
    endcase
  end

  assign sram_en    = req.en & reset_n;
  assign sram_wmode = req.wmode;
  assign sram_addr  = req.addr;
  assign sram_wmask = req.wmask;
  assign sram_wdata = req.wdata;

  array_20_rsp_fifo #(
    .RSP_DEPTH(RSP_DEPTH),
    .WIDTH    (DATA_W)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (inflight),
    .push_data(sram_rdata),
    .pop      (rsp_ready),
    .valid    (rsp_valid),
    .data     (rsp_data),
    .count    (fifo_count)
  );

endmodule
